// File: rtl/block_chk_pkg.sv
// Shared types and constants for the begin/end + fork/join nesting checker.
// Keyword spelling, delimiter set and frame-type encoding live here so matcher and top agree.
package block_chk_pkg;

  typedef enum logic [2:0] {
    KW_NONE  = 3'd0,
    KW_BEGIN = 3'd1,
    KW_END   = 3'd2,
    KW_FORK  = 3'd3,
    KW_JOIN  = 3'd4
  } kw_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_DEAD  = 2'd2
  } trk_state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  localparam int NUM_KW      = 4;
  localparam int MAX_KW_LEN  = 5;

  localparam logic FR_BEGIN = 1'b0;
  localparam logic FR_FORK  = 1'b1;

  function automatic logic is_delim(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? (c + 8'h20) : c;
  endfunction

  // Keyword k (0=begin,1=end,2=fork,3=join), character p; strings are left-aligned in 40 bits.
  function automatic logic [7:0] kw_char(input int unsigned k, input int unsigned p);
    logic [39:0] s;
    int unsigned sh;
    s = 40'h0;
    case (k)
      0: s = "begin";
      1: s = {"end", 16'h0};
      2: s = {"fork", 8'h0};
      3: s = {"join", 8'h0};
      default: s = 40'h0;
    endcase
    sh = (p < 5) ? 8 * (4 - p) : 0;
    return (p < 5) ? s[sh +: 8] : 8'h00;
  endfunction

  function automatic int unsigned kw_len(input int unsigned k);
    case (k)
      0: return 5;
      1: return 3;
      2: return 4;
      3: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic kw_is_opener(input kw_e k);
    return (k == KW_BEGIN) || (k == KW_FORK);
  endfunction

  function automatic logic kw_is_closer(input kw_e k);
    return (k == KW_END) || (k == KW_JOIN);
  endfunction

  function automatic logic kw_frame_type(input kw_e k);
    return ((k == KW_FORK) || (k == KW_JOIN)) ? FR_FORK : FR_BEGIN;
  endfunction

endpackage

// File: rtl/block_nest_checker_kw_matcher.sv
// Word tracker: follows the current word against all keyword prefixes at once and
// reports which keyword (if any) the word equals after the incoming character.
module kw_matcher
  import block_chk_pkg::*;
#(
  parameter bit CASE_SENS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in,
  output kw_e        kw_now,
  output logic       delim
);

  trk_state_e         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [NUM_KW-1:0]  mask_q, mask_d;

  logic [7:0]         ch;
  logic [2:0]         pos;
  logic [NUM_KW-1:0]  cur_mask;
  logic [NUM_KW-1:0]  hit_mask;
  logic               is_delim_ch;

  assign ch          = CASE_SENS ? in : to_lower(in);
  assign is_delim_ch = is_delim(in);
  assign pos         = (state_q == ST_IDLE) ? 3'd0 : idx_q;
  assign cur_mask    = (state_q == ST_IDLE) ? {NUM_KW{1'b1}} : mask_q;

  // A candidate survives only if it is long enough and its next letter matches.
  for (genvar gi = 0; gi < NUM_KW; gi++) begin : g_hit
    assign hit_mask[gi] = cur_mask[gi]
                        && (pos < 3'(kw_len(gi)))
                        && (ch == kw_char(gi, pos));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    if (in_valid) begin
      if (is_delim_ch) begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
        mask_d  = '0;
      end else if (state_q != ST_DEAD) begin
        if ((hit_mask != '0) && (pos < 3'(MAX_KW_LEN))) begin
          state_d = ST_MATCH;
          idx_d   = pos + 3'd1;
          mask_d  = hit_mask;
        end else begin
          state_d = ST_DEAD;
          mask_d  = '0;
        end
      end
    end
  end

  always_comb begin
    delim  = in_valid && is_delim_ch;
    kw_now = KW_NONE;
    if (in_valid && !is_delim_ch && (state_q != ST_DEAD)) begin
      for (int k = 0; k < NUM_KW; k++) begin
        if (hit_mask[k] && (3'(kw_len(k)) == (pos + 3'd1))) begin
          kw_now = kw_e'(3'(k + 1));
        end
      end
    end
  end

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end + fork/join nesting checker: type stack, depth counter,
// sticky error flags and a one-character-lookahead balanced result.
module block_nest_checker
  import block_chk_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit CASE_SENS = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in,
  output logic                       result,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err_underflow,
  output logic                       err_mismatch,
  output logic                       err_overflow
);

  localparam int DW = $clog2(DEPTH + 1);

  kw_e             kw_now;
  logic            delim;

  kw_e             kw_q, kw_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [DEPTH-1:0] stack_q, stack_d;
  logic            err_u_q, err_u_d;
  logic            err_m_q, err_m_d;
  logic            err_o_q, err_o_d;
  logic            result_q, result_d;

  logic            top_type;
  logic            push, pop;
  logic            err_any_q, err_any_d;

  kw_matcher #(
    .CASE_SENS (CASE_SENS)
  ) u_kw_matcher (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in       (in),
    .kw_now   (kw_now),
    .delim    (delim)
  );

  assign err_any_q = err_u_q | err_m_q | err_o_q;
  assign err_any_d = err_u_d | err_m_d | err_o_d;

  always_comb begin
    top_type = FR_BEGIN;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top_type = stack_q[i];
    end
  end

  // kw_q holds the keyword the word-in-progress equals; it is committed on the delimiter.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    err_u_d = err_u_q;
    err_m_d = err_m_q;
    err_o_d = err_o_q;
    if (delim) begin
      if (kw_is_opener(kw_q)) begin
        if (depth_q == DW'(DEPTH)) err_o_d = 1'b1;
        else if (!err_any_q)       push    = 1'b1;
      end else if (kw_is_closer(kw_q)) begin
        if (depth_q == '0)                          err_u_d = 1'b1;
        else if (top_type != kw_frame_type(kw_q))   err_m_d = 1'b1;
        else if (!err_any_q)                        pop     = 1'b1;
      end
    end
  end

  always_comb begin
    depth_d = depth_q;
    if (push)     depth_d = depth_q + DW'(1);
    else if (pop) depth_d = depth_q - DW'(1);
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
    assign stack_d[gi] = (push && (depth_q == DW'(gi))) ? kw_frame_type(kw_q) : stack_q[gi];
  end

  always_comb begin
    kw_d = kw_q;
    if (in_valid) kw_d = delim ? KW_NONE : kw_now;
  end

  // Lookahead: result answers "what if a delimiter arrived right after this character".
  always_comb begin
    result_d = result_q;
    if (in_valid) begin
      if (delim) begin
        result_d = !err_any_d && (depth_d == '0);
      end else if (kw_is_opener(kw_now)) begin
        result_d = 1'b0;
      end else if (kw_is_closer(kw_now)) begin
        result_d = !err_any_q && (depth_q == DW'(1)) && (top_type == kw_frame_type(kw_now));
      end else begin
        result_d = !err_any_q && (depth_q == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kw_q     <= KW_NONE;
      depth_q  <= '0;
      stack_q  <= '0;
      err_u_q  <= 1'b0;
      err_m_q  <= 1'b0;
      err_o_q  <= 1'b0;
      result_q <= 1'b1;
    end else begin
      kw_q     <= kw_d;
      depth_q  <= depth_d;
      stack_q  <= stack_d;
      err_u_q  <= err_u_d;
      err_m_q  <= err_m_d;
      err_o_q  <= err_o_d;
      result_q <= result_d;
    end
  end

  assign result        = result_q;
  assign depth         = depth_q;
  assign err_underflow = err_u_q;
  assign err_mismatch  = err_m_q;
  assign err_overflow  = err_o_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: three instances (DEPTH 16 case-insensitive, DEPTH 16
// lowercase-only, DEPTH 2) share one character stream and are checked against a word-level model.
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'h20;

  always #5 clk = ~clk;

  logic       r0, u0, m0, o0;
  logic [4:0] d0;
  logic       r1, u1, m1, o1;
  logic [4:0] d1;
  logic       r2, u2, m2, o2;
  logic [1:0] d2;

  block_nest_checker #(.DEPTH(16), .CASE_SENS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch), .result(r0), .depth(d0),
    .err_underflow(u0), .err_mismatch(m0), .err_overflow(o0));

  block_nest_checker #(.DEPTH(16), .CASE_SENS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch), .result(r1), .depth(d1),
    .err_underflow(u1), .err_mismatch(m1), .err_overflow(o1));

  block_nest_checker #(.DEPTH(2), .CASE_SENS(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch), .result(r2), .depth(d2),
    .err_underflow(u2), .err_mismatch(m2), .err_overflow(o2));

  logic [8:0] obs [3];
  assign obs[0] = {r0, u0, m0, o0, d0};
  assign obs[1] = {r1, u1, m1, o1, d1};
  assign obs[2] = {r2, u2, m2, o2, 3'b000, d2};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: whole-word comparison and a queue per instance as the frame stack.
  localparam int MAXD [3] = '{16, 16, 2};
  localparam bit MCS  [3] = '{1'b0, 1'b1, 1'b0};
  int    mdepth [3];
  bit    mstk   [3][$];
  bit    mu [3], mm [3], mo [3], mres [3];
  string word;

  // 0 none, 1 begin, 2 end, 3 fork, 4 join
  function automatic int classify(input string w, input bit cs);
    string t;
    t = cs ? w : w.tolower();
    if (t == "begin") return 1;
    if (t == "end")   return 2;
    if (t == "fork")  return 3;
    if (t == "join")  return 4;
    return 0;
  endfunction

  function automatic bit is_ws(input byte c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
  endfunction

  function automatic logic [8:0] exp_vec(input int m);
    return {mres[m], mu[m], mm[m], mo[m], 5'(mdepth[m])};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      mdepth[m] = 0;
      mstk[m].delete();
      mu[m] = 0; mm[m] = 0; mo[m] = 0;
      mres[m] = 1;
    end
    word = "";
  endtask

  task automatic model_step(input byte c, input bit v);
    int  k;
    bit  errs;
    string s1;
    if (!v) return;
    if (is_ws(c)) begin
      for (int m = 0; m < 3; m++) begin
        k = classify(word, MCS[m]);
        errs = mu[m] | mm[m] | mo[m];
        if (k == 1 || k == 3) begin
          if (mdepth[m] == MAXD[m]) mo[m] = 1;
          else if (!errs) begin mstk[m].push_back(k == 3); mdepth[m]++; end
        end else if (k == 2 || k == 4) begin
          if (mdepth[m] == 0) mu[m] = 1;
          else if (mstk[m][$] != (k == 4)) mm[m] = 1;
          else if (!errs) begin void'(mstk[m].pop_back()); mdepth[m]--; end
        end
        mres[m] = !(mu[m] | mm[m] | mo[m]) && (mdepth[m] == 0);
      end
      word = "";
    end else begin
      s1 = " ";
      s1.putc(0, c);
      word = {word, s1};
      for (int m = 0; m < 3; m++) begin
        k = classify(word, MCS[m]);
        errs = mu[m] | mm[m] | mo[m];
        if (k == 1 || k == 3)      mres[m] = 0;
        else if (k == 2 || k == 4) mres[m] = !errs && (mdepth[m] == 1) && (mstk[m][$] == (k == 4));
        else                       mres[m] = !errs && (mdepth[m] == 0);
      end
    end
  endtask

  task automatic drive(input byte c, input bit v);
    @(negedge clk);
    in_ch = c;
    in_valid = v;
    @(posedge clk);
    model_step(c, v);
    #1;
    $display("tx ch=%02h v=%0d obs0=%b obs1=%b obs2=%b", c, v, obs[0], obs[1], obs[2]);
  endtask

  // Reset held across an edge with in_valid high: reset must win.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in_ch = "b";
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1 reset = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) begin
      vectors++;
      if (obs[m] !== exp_vec(m)) begin
        miscompares++;
        $display("FAIL reset_async inst%0d got=%b exp=%b", m, obs[m], exp_vec(m));
      end
    end
    do_reset();
    for (int m = 0; m < 3; m++) begin
      vectors++;
      if (obs[m] !== exp_vec(m)) begin
        miscompares++;
        $display("FAIL reset_wins inst%0d got=%b exp=%b", m, obs[m], exp_vec(m));
      end
    end
  endtask

  task automatic test_nesting();
    string s;
    int    di;
    int    exp_d [4];
    s = "begin fork join end ";
    exp_d = '{1, 2, 1, 0};
    di = 0;
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      for (int m = 0; m < 3; m++) begin
        vectors++;
        if (obs[m] !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL nesting inst%0d idx%0d got=%b exp=%b", m, i, obs[m], exp_vec(m));
        end
      end
      vectors++;
      if (r0 !== ((i < 4) || (i >= 18))) begin
        miscompares++;
        $display("FAIL nesting_result idx%0d got=%b exp=%b", i, r0, ((i < 4) || (i >= 18)));
      end
      if (s[i] == " ") begin
        vectors++;
        if (d0 !== 5'(exp_d[di])) begin
          miscompares++;
          $display("FAIL nesting_depth step%0d got=%0d exp=%0d", di, d0, exp_d[di]);
        end
        di++;
      end
    end
    vectors++;
    if ({u0, m0, o0} !== 3'b000) begin
      miscompares++;
      $display("FAIL nesting_errs got=%b exp=000", {u0, m0, o0});
    end
  endtask

  task automatic test_case();
    string s;
    s = "BeGiN EnD ";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      for (int m = 0; m < 3; m++) begin
        vectors++;
        if (obs[m] !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL case inst%0d idx%0d got=%b exp=%b", m, i, obs[m], exp_vec(m));
        end
      end
      vectors++;
      if ({r1, d1} !== {1'b1, 5'd0}) begin
        miscompares++;
        $display("FAIL case_sens idx%0d got r=%b d=%0d exp r=1 d=0", i, r1, d1);
      end
    end
    vectors++;
    if ({r0, d0, u0, m0, o0} !== {1'b1, 5'd0, 3'b000}) begin
      miscompares++;
      $display("FAIL case_insens_end got r=%b d=%0d e=%b%b%b exp r=1 d=0 e=000", r0, d0, u0, m0, o0);
    end
  endtask

  task automatic test_mismatch();
    string s;
    s = "begin join end ";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      for (int m = 0; m < 3; m++) begin
        vectors++;
        if (obs[m] !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL mismatch inst%0d idx%0d got=%b exp=%b", m, i, obs[m], exp_vec(m));
        end
      end
      if (i >= 10) begin
        vectors++;
        if ({m0, d0, r0} !== {1'b1, 5'd1, 1'b0}) begin
          miscompares++;
          $display("FAIL mismatch_sticky idx%0d got m=%b d=%0d r=%b exp m=1 d=1 r=0", i, m0, d0, r0);
        end
      end
    end
    // Asynchronous reset in mid-cycle clears the sticky error without a clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 3; m++) begin
      vectors++;
      if (obs[m] !== exp_vec(m)) begin
        miscompares++;
        $display("FAIL mismatch_async_clr inst%0d got=%b exp=%b", m, obs[m], exp_vec(m));
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_underflow();
    string s;
    s = "end ";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      for (int m = 0; m < 3; m++) begin
        vectors++;
        if (obs[m] !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL underflow inst%0d idx%0d got=%b exp=%b", m, i, obs[m], exp_vec(m));
        end
      end
    end
    vectors++;
    if ({u0, d0, r0} !== {1'b1, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL underflow_end got u=%b d=%0d r=%b exp u=1 d=0 r=0", u0, d0, r0);
    end
  endtask

  task automatic test_overflow();
    string s;
    s = "begin begin begin ";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      for (int m = 0; m < 3; m++) begin
        vectors++;
        if (obs[m] !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL overflow inst%0d idx%0d got=%b exp=%b", m, i, obs[m], exp_vec(m));
        end
      end
    end
    vectors++;
    if ({o2, d2} !== {1'b1, 2'd2}) begin
      miscompares++;
      $display("FAIL overflow_d2 got o=%b d=%0d exp o=1 d=2", o2, d2);
    end
    vectors++;
    if ({o0, d0} !== {1'b0, 5'd3}) begin
      miscompares++;
      $display("FAIL overflow_d16 got o=%b d=%0d exp o=0 d=3", o0, d0);
    end
  endtask

  task automatic test_hold_and_reset();
    string s;
    byte   c;
    s = "begins beginend begin";
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      for (int m = 0; m < 3; m++) begin
        vectors++;
        if (obs[m] !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL hold_load inst%0d idx%0d got=%b exp=%b", m, i, obs[m], exp_vec(m));
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      c = (i == 2) ? 8'h20 : byte'($urandom_range(32'h21, 32'h7E));
      drive(c, 1'b0);
      vectors++;
      if ({r0, d0} !== {1'b0, 5'd0}) begin
        miscompares++;
        $display("FAIL hold_idle cyc%0d got r=%b d=%0d exp r=0 d=0", i, r0, d0);
      end
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 3; m++) begin
      vectors++;
      if (obs[m] !== exp_vec(m)) begin
        miscompares++;
        $display("FAIL hold_reset inst%0d got=%b exp=%b", m, obs[m], exp_vec(m));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    // The discarded partial word must not leak into the next one.
    s = "end ";
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1);
      for (int m = 0; m < 3; m++) begin
        vectors++;
        if (obs[m] !== exp_vec(m)) begin
          miscompares++;
          $display("FAIL hold_after inst%0d idx%0d got=%b exp=%b", m, i, obs[m], exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_random();
    string toks [12];
    byte   dl [4];
    string t;
    toks = '{"begin", "end", "fork", "join", "BEGIN", "End", "FoRk", "begins", "beg", "joinx", "x", "e"};
    dl = '{8'h20, 8'h09, 8'h0A, 8'h0D};
    for (int b = 0; b < 8; b++) begin
      do_reset();
      for (int n = 0; n < 30; n++) begin
        t = toks[$urandom_range(0, 11)];
        // Bias toward keywords so nesting actually builds up.
        if ($urandom_range(0, 3) != 0) t = toks[$urandom_range(0, 3)];
        for (int i = 0; i <= t.len(); i++) begin
          if ($urandom_range(0, 4) == 0) drive(byte'($urandom_range(32'h20, 32'h7E)), 1'b0);
          drive((i == t.len()) ? dl[$urandom_range(0, 3)] : t[i], 1'b1);
          for (int m = 0; m < 3; m++) begin
            vectors++;
            if (obs[m] !== exp_vec(m)) begin
              miscompares++;
              $display("FAIL random inst%0d burst%0d tok%0d got=%b exp=%b", m, b, n, obs[m], exp_vec(m));
            end
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nesting();
    test_case();
    test_mismatch();
    test_underflow();
    test_overflow();
    test_hold_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
